// File: rtl/buff_pkg.sv
// Shared definitions for the sample buffer: occupancy states, window size and address-width helper.
package buff_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    AVAIL   = 2'd2,
    FULL    = 2'd3
  } buff_state_t;

  localparam int unsigned WIN = 4;

  // Pointer width for a buffer of the given depth; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/buff_ptr.sv
// Modulo-SIZE pointer with increment enable; wraps naturally since SIZE is a power of two.
module buff_ptr
  import buff_pkg::*;
#(
  parameter int unsigned SIZE = 16,
  localparam int unsigned AW  = addr_w(SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/in_to_buff.sv
// Write-side controller of the circular sample buffer; owns both pointers and occupancy.
// Optional sticky protocol checking is enabled with IN_TO_BUFF_ERR_CHECK_EN.
module in_to_buff
  import buff_pkg::*;
#(
  parameter int unsigned SIZE   = 16,
  parameter int unsigned DATA_W = 8,
  localparam int unsigned AW    = addr_w(SIZE),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [AW-1:0]     rd_base,
  output logic              win_valid,
  input  logic              rd_advance,
  output logic [CW-1:0]     count,
  output logic              ovf_err
);

  buff_state_t   state;
  buff_state_t   state_nxt;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;

  // Handshake decode uses registered occupancy only, so no path from rd_advance to in_ready.
  assign in_ready  = (count != CW'(SIZE)) && !rst;
  assign win_valid = (state == AVAIL) || (state == FULL);
  assign push      = in_valid && in_ready;
  assign pop       = rd_advance && win_valid;

  assign wr_en   = push;
  assign wr_data = in_data;

  buff_ptr #(.SIZE(SIZE)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_addr)
  );

  buff_ptr #(.SIZE(SIZE)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_base)
  );

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // State tracks the occupancy band of the next count.
  always_comb begin
    state_nxt = state;
    if (count_nxt == '0) begin
      state_nxt = EMPTY;
    end else if (count_nxt < CW'(WIN)) begin
      state_nxt = PARTIAL;
    end else if (count_nxt < CW'(SIZE)) begin
      state_nxt = AVAIL;
    end else begin
      state_nxt = FULL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      state <= EMPTY;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
    end
  end

`ifdef IN_TO_BUFF_ERR_CHECK_EN
  // Sticky flag: producer pushing into a full buffer or reader stepping without a window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if ((in_valid && (count == CW'(SIZE))) || (rd_advance && !win_valid)) begin
      ovf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_in_to_buff.sv
// Self-checking bench for in_to_buff: occupancy model compared every cycle, plus directed literals.
module tb_in_to_buff;

  localparam int SIZE = 16;
  localparam int DW   = 8;

`ifdef IN_TO_BUFF_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    rd_base;
  logic          win_valid;
  logic          rd_advance = 1'b0;
  logic [4:0]    count;
  logic          ovf_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy and pointers as plain integers.
  int m_count = 0;
  int m_w     = 0;
  int m_r     = 0;
  bit m_ovf   = 1'b0;

  in_to_buff #(.SIZE(SIZE), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_base    (rd_base),
    .win_valid  (win_valid),
    .rd_advance (rd_advance),
    .count      (count),
    .ovf_err    (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return (m_count != SIZE) && !rst;
  endfunction

  function automatic bit exp_win();
    return m_count >= 4;
  endfunction

  task automatic check_all();
    bit push;
    push = in_valid && exp_ready();
    chk("in_ready",  int'(in_ready),  int'(exp_ready()));
    chk("win_valid", int'(win_valid), int'(exp_win()));
    chk("wr_en",     int'(wr_en),     int'(push));
    chk("wr_addr",   int'(wr_addr),   m_w);
    chk("wr_data",   int'(wr_data),   int'(in_data));
    chk("rd_base",   int'(rd_base),   m_r);
    chk("count",     int'(count),     m_count);
    chk("ovf_err",   int'(ovf_err),   int'(m_ovf));
  endtask

  task automatic model_reset();
    m_count = 0;
    m_w     = 0;
    m_r     = 0;
    m_ovf   = 1'b0;
  endtask

  task automatic model_edge(input bit v, input bit adv);
    bit push;
    bit pop;
    if (rst) begin
      model_reset();
    end else begin
      push = v && (m_count != SIZE);
      pop  = adv && (m_count >= 4);
      if (ERR_EN && ((v && m_count == SIZE) || (adv && m_count < 4))) m_ovf = 1'b1;
      if (push) m_w = (m_w + 1) % SIZE;
      if (pop)  m_r = (m_r + 1) % SIZE;
      m_count = m_count + int'(push) - int'(pop);
    end
  endtask

  // One clock: drive, compare on the falling edge, advance the model on the rising edge.
  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit adv);
    in_valid   = v;
    in_data    = d;
    rd_advance = adv;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge(v, adv);
    #1;
  endtask

  initial begin
    int base;
    // Reset held for two cycles, released between edges.
    cycle(1'b1, 8'h55, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("lit_reset_ready", int'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("lit_ready_after_release", int'(in_ready), 1);

    // Four pushes 0x11..0x14.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      #1;
      chk("lit_first_addr", int'(wr_addr), i);
      cycle(1'b1, DW'(8'h11 + i), 1'b0);
      if (i < 3) chk("lit_win_low", int'(win_valid), 0);
    end
    chk("lit_win_after4", int'(win_valid), 1);
    chk("lit_count4", int'(count), 4);
    chk("lit_rd_base0", int'(rd_base), 0);

    // Fill to 16, then a 17th request is refused.
    for (int i = 4; i < 16; i++) cycle(1'b1, DW'(8'h11 + i), 1'b0);
    chk("lit_full_ready", int'(in_ready), 0);
    chk("lit_full_count", int'(count), 16);
    in_valid = 1'b1;
    #1;
    chk("lit_full_wr_en", int'(wr_en), 0);
    cycle(1'b1, 8'hAA, 1'b0);
    chk("lit_ovf_full", int'(ovf_err), int'(ERR_EN));

    // One step from full frees a slot; next write wraps to address 0.
    cycle(1'b0, 8'h00, 1'b1);
    chk("lit_pop_rd_base", int'(rd_base), 1);
    chk("lit_pop_count", int'(count), 15);
    chk("lit_pop_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    #1;
    chk("lit_wrap_addr", int'(wr_addr), 0);
    cycle(1'b1, 8'hBB, 1'b0);

    // Drain to 8, then 20 cycles of simultaneous push and step.
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("lit_count8", int'(count), 8);
    for (int i = 0; i < 20; i++) begin
      base = (int'(wr_addr) - 8 + SIZE) % SIZE;
      chk("lit_base_lag", int'(rd_base), base);
      cycle(1'b1, DW'($urandom), 1'b1);
    end
    chk("lit_count_steady", int'(count), 8);

    // Down to 3 entries: a step request is ignored.
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("lit_count3", int'(count), 3);
    base = int'(rd_base);
    cycle(1'b0, 8'h00, 1'b1);
    chk("lit_ignored_step", int'(rd_base), base);
    chk("lit_ignored_count", int'(count), 3);
    chk("lit_ovf_step", int'(ovf_err), int'(ERR_EN));

    // Fill to 10 and assert reset between edges.
    for (int i = 0; i < 7; i++) cycle(1'b1, DW'(i), 1'b0);
    chk("lit_count10", int'(count), 10);
    in_valid = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    chk("lit_rst_count", int'(count), 0);
    chk("lit_rst_ready", int'(in_ready), 0);
    chk("lit_rst_wr_en", int'(wr_en), 0);
    chk("lit_rst_win", int'(win_valid), 0);
    chk("lit_rst_base", int'(rd_base), 0);
    chk("lit_rst_ovf", int'(ovf_err), 0);
    cycle(1'b1, 8'h77, 1'b0);
    rst = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("lit_post_rst_addr", int'(wr_addr), 0);
    cycle(1'b1, 8'h78, 1'b0);

    // Randomized traffic with varying push/step bias.
    for (int blk = 0; blk < 6; blk++) begin
      int pv;
      int pa;
      pv = 20 + blk * 12;
      pa = 80 - blk * 12;
      for (int i = 0; i < 400; i++) begin
        cycle(bit'($urandom_range(99) < pv), DW'($urandom), bit'($urandom_range(99) < pa));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
